// File: rtl/enc4to2_queue.sv
// Queued 4-to-2 priority encoder: requests accumulate in a pending register and
// drain one 2-bit index per transfer over a valid/ready handshake.
module enc4to2_queue #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       En,
    input  logic       y0,
    input  logic       y1,
    input  logic       y2,
    input  logic       y3,
    output logic [1:0] W,
    output logic       V,
    input  logic       R,
    output logic [3:0] pend,
    output logic [2:0] npend,
    output logic       ovf
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] pend_r;
    logic [3:0] pend_next_s;
    logic [3:0] req_s;
    logic [3:0] grant_s;
    logic [1:0] w_r;
    logic [1:0] w_next_s;
    logic       ovf_r;
    logic       ovf_next_s;
    logic       load_s;

    // One-hot of the highest-priority set bit; direction chosen by PRIO_HIGH.
    function automatic logic [3:0] prio_grant(input logic [3:0] p);
        logic [3:0] g;
        g = 4'b0000;
        if (PRIO_HIGH) begin
            if (p[3])      g = 4'b1000;
            else if (p[2]) g = 4'b0100;
            else if (p[1]) g = 4'b0010;
            else if (p[0]) g = 4'b0001;
            else           g = 4'b0000;
        end else begin
            if (p[0])      g = 4'b0001;
            else if (p[1]) g = 4'b0010;
            else if (p[2]) g = 4'b0100;
            else if (p[3]) g = 4'b1000;
            else           g = 4'b0000;
        end
        return g;
    endfunction

    function automatic logic [1:0] onehot_index(input logic [3:0] g);
        logic [1:0] idx;
        case (g)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic [2:0] popcount4(input logic [3:0] p);
        return {2'b00, p[0]} + {2'b00, p[1]} + {2'b00, p[2]} + {2'b00, p[3]};
    endfunction

    // Request capture, arbitration, pending/overflow update and slot state.
    always_comb begin
        req_s        = En ? {y3, y2, y1, y0} : 4'b0000;
        load_s       = ((state_r == EMPTY) || R) && (pend_r != 4'b0000);
        grant_s      = 4'b0000;
        w_next_s     = w_r;
        ovf_next_s   = ovf_r;
        state_next_s = state_r;

        if (load_s) begin
            grant_s  = prio_grant(pend_r);
            w_next_s = onehot_index(grant_s);
        end else begin
            grant_s  = 4'b0000;
            w_next_s = w_r;
        end

        // A request landing on a bit that is pending and not leaving now is merged.
        pend_next_s = (pend_r & ~grant_s) | req_s;
        if ((req_s & pend_r & ~grant_s) != 4'b0000) begin
            ovf_next_s = 1'b1;
        end else begin
            ovf_next_s = ovf_r;
        end

        case (state_r)
            EMPTY: begin
                if (pend_r != 4'b0000) state_next_s = FULL;
                else                   state_next_s = EMPTY;
            end
            FULL: begin
                if (R) begin
                    if (pend_r != 4'b0000) state_next_s = FULL;
                    else                   state_next_s = EMPTY;
                end else begin
                    state_next_s = FULL;
                end
            end
            default: state_next_s = EMPTY;
        endcase
    end

    // State, token and pending registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= EMPTY;
            pend_r  <= 4'b0000;
            w_r     <= 2'b00;
            ovf_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            pend_r  <= pend_next_s;
            w_r     <= w_next_s;
            ovf_r   <= ovf_next_s;
        end
    end

    assign W     = w_r;
    assign V     = (state_r == FULL);
    assign pend  = pend_r;
    assign npend = popcount4(pend_r);
    assign ovf   = ovf_r;

endmodule

// File: tb/tb_enc4to2_queue.sv
// Bench for enc4to2_queue: directed vector table, hand sequences for reset and
// low-first priority, and random traffic against a pending-set reference model.
module tb_enc4to2_queue;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] y;
    logic       r;

    logic [1:0] w_h, w_l;
    logic       v_h, v_l;
    logic [3:0] pend_h, pend_l;
    logic [2:0] npend_h, npend_l;
    logic       ovf_h, ovf_l;

    int tests;
    int fails;

    // Reference model state, index 0 = high-first instance, 1 = low-first.
    bit [3:0] m_pend [2];
    bit       m_v    [2];
    bit [1:0] m_w    [2];
    bit       m_ovf  [2];

    typedef struct {
        bit       en;
        bit [3:0] y;
        bit       r;
        bit [1:0] w;
        bit       v;
        bit [3:0] pend;
        bit       ovf;
    } vec_t;

    vec_t tbl [29];

    enc4to2_queue #(.PRIO_HIGH(1'b1)) dut_h (
        .clk(clk), .rst(rst), .En(en),
        .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
        .W(w_h), .V(v_h), .R(r),
        .pend(pend_h), .npend(npend_h), .ovf(ovf_h)
    );

    enc4to2_queue #(.PRIO_HIGH(1'b0)) dut_l (
        .clk(clk), .rst(rst), .En(en),
        .y0(y[0]), .y1(y[1]), .y2(y[2]), .y3(y[3]),
        .W(w_l), .V(v_l), .R(r),
        .pend(pend_l), .npend(npend_l), .ovf(ovf_l)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int count_ones(input bit [3:0] p);
        int c;
        c = 0;
        for (int i = 0; i < 4; i++) c += p[i];
        return c;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k] = 4'b0000;
            m_v[k]    = 1'b0;
            m_w[k]    = 2'b00;
            m_ovf[k]  = 1'b0;
        end
    endtask

    // Pending set drained one line per free output slot, best line first.
    task automatic model_step(input int k);
        bit [3:0] rq;
        int       best;
        int       i;
        rq   = en ? y : 4'b0000;
        best = -1;
        if (!m_v[k] || r) begin
            for (int n = 0; n < 4; n++) begin
                i = (k == 0) ? 3 - n : n;
                if (best < 0 && m_pend[k][i]) best = i;
            end
        end
        for (int j = 0; j < 4; j++)
            if (rq[j] && m_pend[k][j] && j != best) m_ovf[k] = 1'b1;
        if (best >= 0) begin
            m_pend[k][best] = 1'b0;
            m_w[k]          = best[1:0];
            m_v[k]          = 1'b1;
        end else if (m_v[k] && r) begin
            m_v[k] = 1'b0;
        end
        m_pend[k] = m_pend[k] | rq;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".h.W"},     {6'd0, w_h},     {6'd0, m_w[0]});
        chk({tag, ".h.V"},     {7'd0, v_h},     {7'd0, m_v[0]});
        chk({tag, ".h.pend"},  {4'd0, pend_h},  {4'd0, m_pend[0]});
        chk({tag, ".h.npend"}, {5'd0, npend_h}, 8'(count_ones(m_pend[0])));
        chk({tag, ".h.ovf"},   {7'd0, ovf_h},   {7'd0, m_ovf[0]});
        chk({tag, ".l.W"},     {6'd0, w_l},     {6'd0, m_w[1]});
        chk({tag, ".l.V"},     {7'd0, v_l},     {7'd0, m_v[1]});
        chk({tag, ".l.pend"},  {4'd0, pend_l},  {4'd0, m_pend[1]});
        chk({tag, ".l.npend"}, {5'd0, npend_l}, 8'(count_ones(m_pend[1])));
        chk({tag, ".l.ovf"},   {7'd0, ovf_l},   {7'd0, m_ovf[1]});
    endtask

    task automatic cycle(input string tag);
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int lo_w [3];
        int lo_n [4];
        tests = 0;
        fails = 0;

        //                en    y        r     W      V     pend     ovf
        tbl[0]  = '{1'b1, 4'b0100, 1'b1, 2'b00, 1'b0, 4'b0100, 1'b0};
        tbl[1]  = '{1'b1, 4'b0000, 1'b1, 2'b10, 1'b1, 4'b0000, 1'b0};
        tbl[2]  = '{1'b1, 4'b0000, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b0};
        tbl[3]  = '{1'b1, 4'b1011, 1'b1, 2'b10, 1'b0, 4'b1011, 1'b0};
        tbl[4]  = '{1'b1, 4'b0000, 1'b1, 2'b11, 1'b1, 4'b0011, 1'b0};
        tbl[5]  = '{1'b1, 4'b0000, 1'b1, 2'b01, 1'b1, 4'b0001, 1'b0};
        tbl[6]  = '{1'b1, 4'b0000, 1'b1, 2'b00, 1'b1, 4'b0000, 1'b0};
        tbl[7]  = '{1'b1, 4'b0000, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0};
        tbl[8]  = '{1'b0, 4'b1111, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0};
        tbl[9]  = '{1'b0, 4'b1111, 1'b1, 2'b00, 1'b0, 4'b0000, 1'b0};
        tbl[10] = '{1'b1, 4'b1000, 1'b1, 2'b00, 1'b0, 4'b1000, 1'b0};
        tbl[11] = '{1'b1, 4'b1000, 1'b1, 2'b11, 1'b1, 4'b1000, 1'b0};
        tbl[12] = '{1'b1, 4'b1000, 1'b1, 2'b11, 1'b1, 4'b1000, 1'b0};
        tbl[13] = '{1'b1, 4'b0000, 1'b1, 2'b11, 1'b1, 4'b0000, 1'b0};
        tbl[14] = '{1'b1, 4'b0000, 1'b1, 2'b11, 1'b0, 4'b0000, 1'b0};
        tbl[15] = '{1'b1, 4'b0010, 1'b0, 2'b11, 1'b0, 4'b0010, 1'b0};
        tbl[16] = '{1'b1, 4'b0000, 1'b0, 2'b01, 1'b1, 4'b0000, 1'b0};
        tbl[17] = '{1'b1, 4'b0000, 1'b0, 2'b01, 1'b1, 4'b0000, 1'b0};
        tbl[18] = '{1'b1, 4'b0000, 1'b0, 2'b01, 1'b1, 4'b0000, 1'b0};
        tbl[19] = '{1'b1, 4'b1000, 1'b0, 2'b01, 1'b1, 4'b1000, 1'b0};
        tbl[20] = '{1'b1, 4'b0000, 1'b0, 2'b01, 1'b1, 4'b1000, 1'b0};
        tbl[21] = '{1'b1, 4'b0000, 1'b1, 2'b11, 1'b1, 4'b0000, 1'b0};
        tbl[22] = '{1'b1, 4'b0000, 1'b0, 2'b11, 1'b1, 4'b0000, 1'b0};
        tbl[23] = '{1'b1, 4'b0100, 1'b0, 2'b11, 1'b1, 4'b0100, 1'b0};
        tbl[24] = '{1'b1, 4'b0000, 1'b0, 2'b11, 1'b1, 4'b0100, 1'b0};
        tbl[25] = '{1'b1, 4'b0100, 1'b0, 2'b11, 1'b1, 4'b0100, 1'b1};
        tbl[26] = '{1'b1, 4'b0000, 1'b1, 2'b10, 1'b1, 4'b0000, 1'b1};
        tbl[27] = '{1'b1, 4'b0000, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b1};
        tbl[28] = '{1'b1, 4'b0000, 1'b1, 2'b10, 1'b0, 4'b0000, 1'b1};

        lo_w = '{0, 1, 3};
        lo_n = '{3, 2, 1, 0};

        // Reset held across edges with every request line active.
        rst = 1'b1;
        en  = 1'b1;
        y   = 4'b1111;
        r   = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        rst = 1'b0;
        y   = 4'b0000;

        foreach (tbl[i]) begin
            en = tbl[i].en;
            y  = tbl[i].y;
            r  = tbl[i].r;
            cycle("tbl");
            chk($sformatf("tbl%0d.W", i),     {6'd0, w_h},     {6'd0, tbl[i].w});
            chk($sformatf("tbl%0d.V", i),     {7'd0, v_h},     {7'd0, tbl[i].v});
            chk($sformatf("tbl%0d.pend", i),  {4'd0, pend_h},  {4'd0, tbl[i].pend});
            chk($sformatf("tbl%0d.npend", i), {5'd0, npend_h}, 8'(count_ones(tbl[i].pend)));
            chk($sformatf("tbl%0d.ovf", i),   {7'd0, ovf_h},   {7'd0, tbl[i].ovf});
        end

        // Asynchronous reset while a token is held under backpressure.
        do_reset();
        en = 1'b1;
        y  = 4'b0010;
        r  = 1'b0;
        cycle("midtok.cap");
        y  = 4'b0000;
        cycle("midtok.load");
        chk("midtok.V_before", {7'd0, v_h}, 8'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("midtok.async.V",    {7'd0, v_h},     8'd0);
        chk("midtok.async.Vl",   {7'd0, v_l},     8'd0);
        chk("midtok.async.W",    {6'd0, w_h},     8'd0);
        chk("midtok.async.pend", {4'd0, pend_h},  8'd0);
        chk("midtok.async.np",   {5'd0, npend_h}, 8'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        r   = 1'b1;
        cycle("postreset");

        // Low-first instance drains a three-line burst as 00, 01, 11.
        y = 4'b1011;
        cycle("lo.cap");
        chk("lo.npend.cap", {5'd0, npend_l}, 8'(lo_n[0]));
        y = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            cycle("lo.drain");
            chk($sformatf("lo.W%0d", i),     {6'd0, w_l},     8'(lo_w[i]));
            chk($sformatf("lo.V%0d", i),     {7'd0, v_l},     8'd1);
            chk($sformatf("lo.npend%0d", i), {5'd0, npend_l}, 8'(lo_n[i + 1]));
        end
        cycle("lo.idle");
        chk("lo.V_end",  {7'd0, v_l},   8'd0);
        chk("lo.ovf",    {7'd0, ovf_l}, 8'd0);

        // Random traffic against the reference model, with occasional resets.
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                check_all("rnd.reset");
            end
            en = ($urandom_range(0, 9) != 0);
            y  = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
            r  = ($urandom_range(0, 3) != 0);
            cycle("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enc4to2_queue.md
Name: enc4to2_queue

Overview:
- Sequential counterpart of the team's 2-to-4 decoder (dec2to4): turns four request lines y0..y3 back into a 2-bit index W.
- Requests are captured into a pending register, arbitrated by fixed priority, and emitted one code at a time over a valid/ready handshake.
- Sits upstream of a dec2to4 instance or any consumer of a 2-bit index. Never loses a single request per line; flags collisions.

Parameters:
- PRIO_HIGH, 1, 1 = y3 highest priority (y3>y2>y1>y0); 0 = y0 highest (y0>y1>y2>y3).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- En  input  1  capture enable; y0..y3 ignored when 0.
- y0  input  1  request line, index 0.
- y1  input  1  request line, index 1.
- y2  input  1  request line, index 2.
- y3  input  1  request line, index 3.
- W  output  2  encoded index of the current output token.
- V  output  1  W valid.
- R  input  1  consumer ready; token transfers on a cycle with V=1 and R=1.
- pend  output  4  pending request bits; bit i = yi.
- npend  output  3  population count of pend, combinational from pend, range 0..4.
- ovf  output  1  sticky overflow flag.

Behaviour:
- Reset (async, while rst=1): pend=0, W=2'b00, V=0, ovf=0, npend=0. Reset mid-handshake discards the token and all pending bits. No pulse is produced on release.
- Request vector: req = En ? {y3,y2,y1,y0} : 4'b0000. Level-sampled every cycle; a line held high re-requests every cycle.
- Output slot is free when (V==0) or (V==1 and R==1).
- Load happens when the slot is free and pend!=0:
  - grant = one-hot of the highest-priority set bit of the registered pend, per PRIO_HIGH.
  - W <= index of grant; V <= 1.
- Slot free, pend==0, V==1, R==1: V <= 0; W holds its last value.
- V==1 and R==0: W and V hold, no load, grant=0.
- Pending update: pend_next = (pend & ~grant) | req.
  - Re-request of the bit being granted in the same cycle leaves that bit set: a new token follows.
- Overflow: ovf <= 1 on any cycle where (req & pend & ~grant) != 0, i.e. a request hits a still-pending, ungranted bit.
  - The duplicate is merged, not queued. ovf clears only on rst.
- Latency: yi sampled at edge t sets pend[i] at t. With an idle slot, V=1 and W=i after edge t+1.
  - Throughput is 1 token/cycle when R is held 1.
- Back-to-back: with R=1, tokens drain one per cycle in priority order. V drops the cycle after the last transfer if pend is empty.
- Starvation is allowed by design: a continuously re-asserted higher-priority line starves lower ones.
- Simultaneous requests on several lines in one cycle: all captured, emitted in priority order, no ovf.
- En=0 does not affect draining of already-pending bits.
- State machine (V as state):
  - EMPTY: V=0. Goes to FULL when pend!=0.
  - FULL: V=1. On R=1, stays FULL if pend!=0 (reload); goes to EMPTY if pend==0. On R=0, stays FULL.

Test Plan:
- Reset: rst=1 with y0..y3=1, En=1 → W=00, V=0, pend=0000, ovf=0, npend=0. Assert rst mid-token (V=1) → V=0 immediately without a clock edge.
- Single request, PRIO_HIGH=1, R=1: En=1, y2 pulse one cycle → pend=0100 after edge t, then W=10, V=1 after edge t+1. V=0 one cycle later.
- Multi-request: y0,y1,y3 pulsed together, R=1 → W sequence 11, 01, 00 on consecutive cycles, then V=0. ovf=0, npend goes 3→2→1→0. With PRIO_HIGH=0 → sequence 00, 01, 11.
- Backpressure: load y1, hold R=0 for 5 cycles → W=01, V=1 stable. Pulse y3 during the stall → pend=1000. Release R → W=11 the next cycle.
- Overflow: R=0, V=1; pulse y2 twice on separate cycles → ovf=1 on the second. Still only one y2 token emitted after R=1. ovf stays 1 until rst.
- Enable gating and re-arm: En=0 with y0..y3=1111 → pend unchanged, V stays 0. En=1, y3 held high, R=1 → W=11 every cycle, V continuous, no ovf.
